// File: rtl/test_pulse_encoder_if.sv
// test_pulse_encoder_if: button-in / test-strobe-out bundle between the board pin and the control unit.
interface test_pulse_encoder_if;
    logic       btn_raw;
    logic       botonTest;
    logic [3:0] pulseTest;
    logic       busy;
    logic       cancel;
    modport master (output btn_raw, input botonTest, pulseTest, busy, cancel);
    modport slave  (input btn_raw, output botonTest, pulseTest, busy, cancel);
endinterface

// File: rtl/test_pulse_encoder.sv
// test_pulse_encoder: synchronizes, debounces and counts test-button presses, strobing the count when a burst closes.
// Optional long-press abort is enabled by defining TPE_CANCEL_EN.
module test_pulse_encoder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int WINDOW_CYCLES   = 20,
    parameter int LONG_CYCLES     = 40,
    parameter int MAX_PULSES      = 15
) (
    input logic clk,
    input logic rst,
    test_pulse_encoder_if.slave bus
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(WINDOW_CYCLES + 1);

    if (MAX_PULSES < 1 || MAX_PULSES > 15 || DEBOUNCE_CYCLES < 1 || WINDOW_CYCLES < 1 || LONG_CYCLES < 1) begin : g_bad_params
        $error("test_pulse_encoder: illegal parameter value");
    end

    typedef enum logic [1:0] {IDLE, COUNT, EMIT} state_t;

    logic          s1, s2, db, pe;
    logic [DW-1:0] dcnt;
    logic [DW-1:0] dcnt_nx;
    state_t        state;
    logic [3:0]    cnt;
    logic [3:0]    cnt_sat;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_nx;
    logic [3:0]    pulse_q;
    logic          boton_q, busy_q;

    assign dcnt_nx  = dcnt + 1'b1;
    assign timer_nx = timer + 1'b1;
    assign cnt_sat  = (cnt == 4'(MAX_PULSES)) ? cnt : cnt + 4'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            db   <= 1'b0;
            dcnt <= '0;
            pe   <= 1'b0;
        end else begin
            s1 <= bus.btn_raw;
            s2 <= s1;
            pe <= 1'b0;
            if (s2 == db) begin
                dcnt <= '0;
            end else if (dcnt_nx == DW'(DEBOUNCE_CYCLES)) begin
                db   <= s2;
                dcnt <= '0;
                pe   <= s2;
            end else begin
                dcnt <= dcnt_nx;
            end
        end
    end

`ifdef TPE_CANCEL_EN
    localparam int LW = $clog2(LONG_CYCLES + 1);
    logic [LW-1:0] hold;
    logic [LW-1:0] hold_nx;
    logic          cancel_q;
    assign hold_nx    = hold + 1'b1;
    assign bus.cancel = cancel_q;
`else
    assign bus.cancel = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            timer   <= '0;
            pulse_q <= '0;
            boton_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef TPE_CANCEL_EN
            hold     <= '0;
            cancel_q <= 1'b0;
`endif
        end else begin
            boton_q <= 1'b0;
`ifdef TPE_CANCEL_EN
            cancel_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (pe) begin
                        state  <= COUNT;
                        cnt    <= 4'd1;
                        timer  <= '0;
                        busy_q <= 1'b1;
`ifdef TPE_CANCEL_EN
                        hold   <= '0;
`endif
                    end
                end
                COUNT: begin
                    if (pe) begin
                        cnt   <= cnt_sat;
                        timer <= '0;
                    end else if (!db) begin
                        if (timer_nx == TW'(WINDOW_CYCLES)) begin
                            state   <= EMIT;
                            pulse_q <= cnt;
                            boton_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            timer <= timer_nx;
                        end
                    end
`ifdef TPE_CANCEL_EN
                    // hold is cleared at every release, so it only reaches the limit on one continuous press
                    hold <= db ? hold_nx : '0;
                    if (db && hold_nx == LW'(LONG_CYCLES)) begin
                        state    <= IDLE;
                        busy_q   <= 1'b0;
                        cancel_q <= 1'b1;
                        hold     <= '0;
                    end
`endif
                end
                default: begin
                    if (pe) begin
                        state  <= COUNT;
                        cnt    <= 4'd1;
                        timer  <= '0;
                        busy_q <= 1'b1;
`ifdef TPE_CANCEL_EN
                        hold   <= '0;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.botonTest = boton_q;
    assign bus.pulseTest = pulse_q;
    assign bus.busy      = busy_q;
endmodule
